// File: rtl/rgb2gray_pipe_pkg.sv
// Shared video constants: default luma weights, RGB channel slice offsets and
// the bundle of timing bits carried alongside pixel data.
package video_pkg;

  localparam int unsigned LUMA_COEF_R     = 77;
  localparam int unsigned LUMA_COEF_G     = 150;
  localparam int unsigned LUMA_COEF_B     = 29;
  localparam int unsigned LUMA_COEF_WIDTH = 9;
  localparam int unsigned LUMA_SHIFT      = 8;

  localparam int unsigned RGB_R_LSB = 16;
  localparam int unsigned RGB_G_LSB = 8;
  localparam int unsigned RGB_B_LSB = 0;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } vid_timing_t;

  localparam int unsigned VID_TIMING_W = $bits(vid_timing_t);

endpackage

// File: rtl/rgb2gray_pipe_if.sv
// RGB-in / gray-out video stream bundle; master drives pixels, slave converts.
interface rgb2gray_pipe_if #(
  parameter int unsigned VIDEO_GRAY_DATA_WIDTH = 8,
  parameter int unsigned VIDEO_RGB_DATA_WIDTH  = 3 * VIDEO_GRAY_DATA_WIDTH
);

  logic                             vid_in_active;
  logic [VIDEO_RGB_DATA_WIDTH-1:0]  vid_in_data;
  logic                             vid_in_hsync;
  logic                             vid_in_vsync;
  logic                             vid_out_active;
  logic [VIDEO_GRAY_DATA_WIDTH-1:0] vid_out_data;
  logic                             vid_out_hsync;
  logic                             vid_out_vsync;

  modport master (
    output vid_in_active, vid_in_data, vid_in_hsync, vid_in_vsync,
    input  vid_out_active, vid_out_data, vid_out_hsync, vid_out_vsync
  );

  modport slave (
    input  vid_in_active, vid_in_data, vid_in_hsync, vid_in_vsync,
    output vid_out_active, vid_out_data, vid_out_hsync, vid_out_vsync
  );

endinterface

// File: rtl/rgb2gray_pipe_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear, used to keep
// sideband bits aligned with a pipelined datapath.
module video_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

  if (DEPTH == 0) begin : g_bad_depth
    $error("video_delay_line: DEPTH must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign data_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rgb2gray_pipe.sv
// 3-stage RGB to luma converter: multiply, sum with round-half-up bias,
// shift and saturate. Sync/active bits are delayed to stay aligned.
module rgb2gray_pipe
  import video_pkg::*;
#(
  parameter int unsigned VIDEO_GRAY_DATA_WIDTH = 8,
  parameter int unsigned VIDEO_RGB_DATA_WIDTH  = VIDEO_GRAY_DATA_WIDTH * 3,
  parameter int unsigned COEF_WIDTH            = LUMA_COEF_WIDTH,
  parameter int unsigned COEF_R                = LUMA_COEF_R,
  parameter int unsigned COEF_G                = LUMA_COEF_G,
  parameter int unsigned COEF_B                = LUMA_COEF_B,
  parameter int unsigned COEF_SHIFT            = LUMA_SHIFT
) (
  input  logic          clk,
  input  logic          rst_n,
  rgb2gray_pipe_if.slave vid
);

  localparam int unsigned W  = VIDEO_GRAY_DATA_WIDTH;
  localparam int unsigned PW = W + COEF_WIDTH;
  localparam int unsigned SW = PW + 2;

  localparam logic [COEF_WIDTH-1:0] CR = COEF_WIDTH'(COEF_R);
  localparam logic [COEF_WIDTH-1:0] CG = COEF_WIDTH'(COEF_G);
  localparam logic [COEF_WIDTH-1:0] CB = COEF_WIDTH'(COEF_B);
  localparam logic [SW-1:0] ROUND    = SW'(1) << (COEF_SHIFT - 1);
  localparam logic [SW-1:0] GRAY_MAX = {{(SW-W){1'b0}}, {W{1'b1}}};

  if (COEF_SHIFT == 0) begin : g_bad_shift
    $error("rgb2gray_pipe: COEF_SHIFT must be at least 1");
  end
  if (COEF_R >= 2**COEF_WIDTH || COEF_G >= 2**COEF_WIDTH || COEF_B >= 2**COEF_WIDTH) begin : g_bad_coef
    $error("rgb2gray_pipe: coefficient does not fit in COEF_WIDTH bits");
  end
  if (VIDEO_RGB_DATA_WIDTH != 3 * VIDEO_GRAY_DATA_WIDTH) begin : g_bad_rgb_w
    $error("rgb2gray_pipe: VIDEO_RGB_DATA_WIDTH must be 3*VIDEO_GRAY_DATA_WIDTH");
  end

  logic [W-1:0]  r_w, g_w, b_w;
  logic [PW-1:0] pr_d, pg_d, pb_d, pr_q, pg_q, pb_q;
  logic [SW-1:0] sum_d, sum_q, y_w;
  logic [W-1:0]  gray_d, gray_q;
  vid_timing_t   tim_in, tim_out;

  assign r_w = vid.vid_in_data[RGB_R_LSB +: W];
  assign g_w = vid.vid_in_data[RGB_G_LSB +: W];
  assign b_w = vid.vid_in_data[RGB_B_LSB +: W];

  always_comb begin
    pr_d  = PW'(r_w) * PW'(CR);
    pg_d  = PW'(g_w) * PW'(CG);
    pb_d  = PW'(b_w) * PW'(CB);
    sum_d = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + ROUND;
    y_w   = sum_q >> COEF_SHIFT;
    gray_d = (y_w > GRAY_MAX) ? '1 : y_w[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      sum_q  <= '0;
      gray_q <= '0;
    end else begin
      pr_q   <= pr_d;
      pg_q   <= pg_d;
      pb_q   <= pb_d;
      sum_q  <= sum_d;
      gray_q <= gray_d;
    end
  end

  assign tim_in = '{active: vid.vid_in_active, hsync: vid.vid_in_hsync, vsync: vid.vid_in_vsync};

  video_delay_line #(
    .WIDTH (VID_TIMING_W),
    .DEPTH (3)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (tim_in),
    .data_o (tim_out)
  );

  // Final-stage active is the registered S2 active bit, so masking here is
  // equivalent to zeroing the S3 data register when S2 active is low.
  assign vid.vid_out_data   = tim_out.active ? gray_q : '0;
  assign vid.vid_out_active = tim_out.active;
  assign vid.vid_out_hsync  = tim_out.hsync;
  assign vid.vid_out_vsync  = tim_out.vsync;

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Scoreboard bench for rgb2gray_pipe: default weights and a saturating
// 511/0/0 variant are driven with identical streams and checked in parallel.
module tb_rgb2gray_pipe;

  typedef struct {
    int         due;
    logic [2:0] tim;
    logic [7:0] ya;
    logic [7:0] yb;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst_req;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  rgb2gray_pipe_if #(.VIDEO_GRAY_DATA_WIDTH(8)) if_a ();
  rgb2gray_pipe_if #(.VIDEO_GRAY_DATA_WIDTH(8)) if_b ();

  rgb2gray_pipe u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (if_a)
  );

  rgb2gray_pipe #(
    .COEF_R (511),
    .COEF_G (0),
    .COEF_B (0)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] luma(input int r, input int g, input int b,
                                      input int cr, input int cg, input int cb, input int sh);
    int y;
    y = (r * cr + g * cg + b * cb + (1 << (sh - 1))) >> sh;
    if (y > 255) y = 255;
    return y[7:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  task automatic drive(input logic a, input logic h, input logic v, input logic [23:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst_req;
    if_a.vid_in_active = a; if_a.vid_in_hsync = h; if_a.vid_in_vsync = v; if_a.vid_in_data = d;
    if_b.vid_in_active = a; if_b.vid_in_hsync = h; if_b.vid_in_vsync = v; if_b.vid_in_data = d;
    e.due = cyc + 3;
    e.tim = rst_req ? {a, h, v} : 3'b000;
    e.ya  = (rst_req && a) ? luma(int'(d[23:16]), int'(d[15:8]), int'(d[7:0]), 77, 150, 29, 8) : '0;
    e.yb  = (rst_req && a) ? luma(int'(d[23:16]), int'(d[15:8]), int'(d[7:0]), 511, 0, 0, 8) : '0;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_a"}, int'({if_a.vid_out_active, if_a.vid_out_hsync, if_a.vid_out_vsync, if_a.vid_out_data}), 0);
    chk({name, "_b"}, int'({if_b.vid_out_active, if_b.vid_out_hsync, if_b.vid_out_vsync, if_b.vid_out_data}), 0);
  endtask

  // Monitor: every output cycle is matched to the pixel driven three cycles earlier.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("timing_a", int'({if_a.vid_out_active, if_a.vid_out_hsync, if_a.vid_out_vsync}), int'(e.tim));
        chk("timing_b", int'({if_b.vid_out_active, if_b.vid_out_hsync, if_b.vid_out_vsync}), int'(e.tim));
        chk("gray_a", int'(if_a.vid_out_data), int'(e.ya));
        chk("gray_b", int'(if_b.vid_out_data), int'(e.yb));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rst_req  = 1'b0;
    if_a.vid_in_active = 1'b0; if_a.vid_in_hsync = 1'b0; if_a.vid_in_vsync = 1'b0; if_a.vid_in_data = '0;
    if_b.vid_in_active = 1'b0; if_b.vid_in_hsync = 1'b0; if_b.vid_in_vsync = 1'b0; if_b.vid_in_data = '0;

    // Reset held with random inputs: everything must stay zero.
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
    end
    #1;
    check_all_zero("reset_hold");

    // Release and white pixel, then primaries and the saturating-variant cases.
    rst_req = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
    drive(1'b1, 1'b0, 1'b0, 24'hFF0000);
    drive(1'b1, 1'b0, 1'b0, 24'h00FF00);
    drive(1'b1, 1'b0, 1'b0, 24'h0000FF);
    drive(1'b1, 1'b0, 1'b0, 24'h6496C8);
    drive(1'b1, 1'b0, 1'b0, 24'h800000);
    drive(1'b1, 1'b0, 1'b0, 24'h640000);
    drive(1'b1, 1'b0, 1'b0, 24'h000000);

    // Blanking with full-scale data and sync pulse patterns.
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, (i % 3) == 0, (i % 5) == 1, 24'hFFFFFF);
    end

    // Active toggling every cycle with random data and syncs.
    for (int i = 0; i < 16; i++) begin
      drive(1'(i % 2), 1'($urandom), 1'($urandom), 24'($urandom));
    end

    // Asynchronous reset mid-cycle while a burst of pixels is in flight.
    for (int i = 0; i < 10; i++) begin
      if (i == 7) rst_req = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 24'($urandom));
      if (i == 4) begin
        #2;
        rst_n   = 1'b0;
        rst_req = 1'b0;
        for (int k = 0; k < sb.size(); k++) begin
          sb[k].tim = 3'b000;
          sb[k].ya  = '0;
          sb[k].yb  = '0;
        end
        #1;
        check_all_zero("async_reset");
      end
    end

    // One full line of random pixels.
    for (int i = 0; i < 1920; i++) begin
      drive(($urandom % 8) != 0, i < 16, ($urandom % 64) == 0, 24'($urandom));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
